grid_world_env: RTL and testbench

GRID_WORLD_ENV -- requirements
Module: grid_world_env

---
 rtl/grid_world_env.sv | 136 +++++++++++++
 tb/tb_grid_world_env.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/grid_world_env.sv
// 8x8 grid-world environment for a reinforcement-learning agent.
// Accepts one-hot moves, returns the new cell and a Q8.8 reward, and auto-restarts episodes.
module grid_world_env #(
    parameter logic [5:0]         START_STATE = 6'd0,
    parameter logic [5:0]         GOAL_STATE  = 6'd63,
    parameter logic [5:0]         PIT_STATE   = 6'd27,
    parameter logic [7:0]         MAX_STEPS   = 8'd64,
    parameter logic signed [15:0] R_GOAL      = 16'sd256,
    parameter logic signed [15:0] R_PIT       = -16'sd256,
    parameter logic signed [15:0] R_STEP      = -16'sd4,
    parameter logic signed [15:0] R_WALL      = -16'sd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               action_valid,
    input  logic [3:0]         action,
    output logic [5:0]         next_state,
    output logic signed [15:0] next_reward,
    output logic               out_valid,
    output logic               episode_done,
    output logic [7:0]         step_count,
    output logic [15:0]        episode_count
);

    typedef enum logic [1:0] {ST_RUN, ST_TERM, ST_RESTART} fsm_t;

    fsm_t               r_fsm;
    fsm_t               w_fsm_next;
    logic [5:0]         r_cell,     w_cell_next;
    logic signed [15:0] r_reward,   w_reward_next;
    logic               r_out_valid, w_out_valid_next;
    logic               r_done,     w_done_next;
    logic [7:0]         r_steps,    w_steps_next;
    logic [15:0]        r_episodes, w_episodes_next;

    logic [2:0] w_row, w_col;
    logic [5:0] w_target;
    logic       w_legal;
    logic [7:0] w_steps_inc;
    logic       w_hit_goal, w_hit_pit, w_timeout;

    // Target cell; anything that is not a single in-grid move leaves the agent in place.
    always_comb begin
        w_row    = r_cell[5:3];
        w_col    = r_cell[2:0];
        w_target = r_cell;
        w_legal  = 1'b0;
        case (action)
            4'b0001: begin w_legal = (w_row != 3'd0); w_target = {w_row - 3'd1, w_col}; end
            4'b0010: begin w_legal = (w_row != 3'd7); w_target = {w_row + 3'd1, w_col}; end
            4'b0100: begin w_legal = (w_col != 3'd0); w_target = {w_row, w_col - 3'd1}; end
            4'b1000: begin w_legal = (w_col != 3'd7); w_target = {w_row, w_col + 3'd1}; end
            default: begin w_legal = 1'b0; w_target = r_cell; end
        endcase
        if (!w_legal) begin
            w_target = r_cell;
        end
        w_steps_inc = r_steps + 8'd1;
        w_hit_goal  = w_legal && (w_target == GOAL_STATE);
        w_hit_pit   = w_legal && (w_target == PIT_STATE);
        w_timeout   = (w_steps_inc == MAX_STEPS);
    end

    always_comb begin
        w_fsm_next       = r_fsm;
        w_cell_next      = r_cell;
        w_reward_next    = r_reward;
        w_out_valid_next = 1'b0;
        w_done_next      = 1'b0;
        w_steps_next     = r_steps;
        w_episodes_next  = r_episodes;
        case (r_fsm)
            ST_RUN: begin
                if (en && action_valid) begin
                    w_cell_next      = w_target;
                    w_out_valid_next = 1'b1;
                    w_steps_next     = w_steps_inc;
                    // Cell reward takes priority over the plain step/wall penalty.
                    if (w_hit_goal)      w_reward_next = R_GOAL;
                    else if (w_hit_pit)  w_reward_next = R_PIT;
                    else if (w_legal)    w_reward_next = R_STEP;
                    else                 w_reward_next = R_WALL;
                    if (w_hit_goal || w_hit_pit || w_timeout) begin
                        w_done_next = 1'b1;
                        w_fsm_next  = ST_TERM;
                    end
                end
            end
            ST_TERM: begin
                w_fsm_next = ST_RESTART;
            end
            ST_RESTART: begin
                w_cell_next      = START_STATE;
                w_reward_next    = '0;
                w_out_valid_next = 1'b1;
                w_steps_next     = '0;
                if (r_episodes != 16'hFFFF) begin
                    w_episodes_next = r_episodes + 16'd1;
                end
                w_fsm_next = ST_RUN;
            end
            default: begin
                w_fsm_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= ST_RUN;
            r_cell      <= START_STATE;
            r_reward    <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_steps     <= '0;
            r_episodes  <= '0;
        end else begin
            r_fsm       <= w_fsm_next;
            r_cell      <= w_cell_next;
            r_reward    <= w_reward_next;
            r_out_valid <= w_out_valid_next;
            r_done      <= w_done_next;
            r_steps     <= w_steps_next;
            r_episodes  <= w_episodes_next;
        end
    end

    assign next_state    = r_cell;
    assign next_reward   = r_reward;
    assign out_valid     = r_out_valid;
    assign episode_done  = r_done;
    assign step_count    = r_steps;
    assign episode_count = r_episodes;

endmodule

// File: tb/tb_grid_world_env.sv
// Directed bench for grid_world_env: moves, walls, terminals, timeout, freeze and reset.
// Observed word = {next_state, next_reward, out_valid, episode_done, step_count, episode_count}.
module tb_grid_world_env;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               action_valid;
    logic [3:0]         action;
    logic [5:0]         next_state;
    logic signed [15:0] next_reward;
    logic               out_valid;
    logic               episode_done;
    logic [7:0]         step_count;
    logic [15:0]        episode_count;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] RW_GOAL = 16'h0100;
    localparam logic [15:0] RW_PIT  = 16'hFF00;
    localparam logic [15:0] RW_STEP = 16'hFFFC;
    localparam logic [15:0] RW_WALL = 16'hFFF0;

    logic [47:0] obs;
    logic [47:0] exp_v;
    assign obs = {next_state, next_reward, out_valid, episode_done, step_count, episode_count};

    grid_world_env dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .action_valid (action_valid),
        .action       (action),
        .next_state   (next_state),
        .next_reward  (next_reward),
        .out_valid    (out_valid),
        .episode_done (episode_done),
        .step_count   (step_count),
        .episode_count(episode_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        $display("txn rst=%0b en=%0b v=%0b act=%b -> state=%0d reward=%0d ov=%0b done=%0b step=%0d ep=%0d",
                 rst, en, action_valid, action, next_state, next_reward, out_valid,
                 episode_done, step_count, episode_count);
    endtask

    task automatic do_action(input logic [3:0] a);
        en = 1'b1;
        action_valid = 1'b1;
        action = a;
        tick();
    endtask

    task automatic idle();
        action_valid = 1'b0;
        tick();
    endtask

    task automatic walk(input logic [3:0] a, input int n);
        for (int k = 0; k < n; k++) do_action(a);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; action_valid = 1'b1; action = 4'b1000;
        tick();
        tick();
        checks++; exp_v = {6'd0, 16'h0000, 1'b0, 1'b0, 8'd0, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL reset: got %h want %h", obs, exp_v); end
        rst = 1'b0; action_valid = 1'b0;
    endtask

    task automatic test_step();
        do_action(4'b1000);
        checks++; exp_v = {6'd1, RW_STEP, 1'b1, 1'b0, 8'd1, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL first_right: got %h want %h", obs, exp_v); end
        idle();
        checks++; exp_v = {6'd1, RW_STEP, 1'b0, 1'b0, 8'd1, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL valid_drop: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_wall();
        do_action(4'b0100);
        checks++; exp_v = {6'd0, RW_STEP, 1'b1, 1'b0, 8'd2, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL left_to_0: got %h want %h", obs, exp_v); end
        do_action(4'b0001);
        checks++; exp_v = {6'd0, RW_WALL, 1'b1, 1'b0, 8'd3, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL up_wall: got %h want %h", obs, exp_v); end
        do_action(4'b0110);
        checks++; exp_v = {6'd0, RW_WALL, 1'b1, 1'b0, 8'd4, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL two_hot: got %h want %h", obs, exp_v); end
        do_action(4'b0000);
        checks++; exp_v = {6'd0, RW_WALL, 1'b1, 1'b0, 8'd5, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL zero_hot: got %h want %h", obs, exp_v); end
        do_action(4'b0100);
        checks++; exp_v = {6'd0, RW_WALL, 1'b1, 1'b0, 8'd6, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL left_wall: got %h want %h", obs, exp_v); end
        do_action(4'b0010);
        checks++; exp_v = {6'd8, RW_STEP, 1'b1, 1'b0, 8'd7, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL down_step: got %h want %h", obs, exp_v); end
        do_action(4'b1111);
        checks++; exp_v = {6'd8, RW_WALL, 1'b1, 1'b0, 8'd8, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL all_hot: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_freeze();
        en = 1'b0; action_valid = 1'b1; action = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; exp_v = {6'd8, RW_WALL, 1'b0, 1'b0, 8'd8, 16'd0};
            if (obs !== exp_v) begin errors++; $display("FAIL freeze%0d: got %h want %h", k, obs, exp_v); end
        end
        action_valid = 1'b0; en = 1'b1;
    endtask

    task automatic test_goal();
        rst = 1'b1; action_valid = 1'b1; action = 4'b1000;
        tick();
        checks++; exp_v = {6'd0, 16'h0000, 1'b0, 1'b0, 8'd0, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL mid_reset: got %h want %h", obs, exp_v); end
        rst = 1'b0;
        walk(4'b1000, 6);
        walk(4'b0010, 7);
        checks++; exp_v = {6'd62, RW_STEP, 1'b1, 1'b0, 8'd13, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL reach_62: got %h want %h", obs, exp_v); end
        do_action(4'b1000);
        checks++; exp_v = {6'd63, RW_GOAL, 1'b1, 1'b1, 8'd14, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL goal: got %h want %h", obs, exp_v); end
        action = 4'b0100;
        tick();
        checks++; exp_v = {6'd63, RW_GOAL, 1'b0, 1'b0, 8'd14, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL goal_term: got %h want %h", obs, exp_v); end
        tick();
        checks++; exp_v = {6'd0, 16'h0000, 1'b1, 1'b0, 8'd0, 16'd1};
        if (obs !== exp_v) begin errors++; $display("FAIL goal_restart: got %h want %h", obs, exp_v); end
        idle();
        checks++; exp_v = {6'd0, 16'h0000, 1'b0, 1'b0, 8'd0, 16'd1};
        if (obs !== exp_v) begin errors++; $display("FAIL goal_after: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_pit();
        walk(4'b1000, 2);
        walk(4'b0010, 3);
        checks++; exp_v = {6'd26, RW_STEP, 1'b1, 1'b0, 8'd5, 16'd1};
        if (obs !== exp_v) begin errors++; $display("FAIL reach_26: got %h want %h", obs, exp_v); end
        do_action(4'b1000);
        checks++; exp_v = {6'd27, RW_PIT, 1'b1, 1'b1, 8'd6, 16'd1};
        if (obs !== exp_v) begin errors++; $display("FAIL pit: got %h want %h", obs, exp_v); end
        tick();
        checks++; exp_v = {6'd27, RW_PIT, 1'b0, 1'b0, 8'd6, 16'd1};
        if (obs !== exp_v) begin errors++; $display("FAIL pit_term: got %h want %h", obs, exp_v); end
        tick();
        checks++; exp_v = {6'd0, 16'h0000, 1'b1, 1'b0, 8'd0, 16'd2};
        if (obs !== exp_v) begin errors++; $display("FAIL pit_restart: got %h want %h", obs, exp_v); end
        idle();
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 64; i++) begin
            do_action((i % 2 == 1) ? 4'b1000 : 4'b0100);
            checks++;
            exp_v = {((i % 2 == 1) ? 6'd1 : 6'd0), RW_STEP, 1'b1, (i == 64), 8'(i), 16'd2};
            if (obs !== exp_v) begin errors++; $display("FAIL timeout_step%0d: got %h want %h", i, obs, exp_v); end
        end
        tick();
        checks++; exp_v = {6'd0, RW_STEP, 1'b0, 1'b0, 8'd64, 16'd2};
        if (obs !== exp_v) begin errors++; $display("FAIL timeout_term: got %h want %h", obs, exp_v); end
        tick();
        checks++; exp_v = {6'd0, 16'h0000, 1'b1, 1'b0, 8'd0, 16'd3};
        if (obs !== exp_v) begin errors++; $display("FAIL timeout_restart: got %h want %h", obs, exp_v); end
        idle();
    endtask

    task automatic test_timeout_goal();
        walk(4'b0001, 50);
        walk(4'b1000, 6);
        walk(4'b0010, 7);
        checks++; exp_v = {6'd62, RW_STEP, 1'b1, 1'b0, 8'd63, 16'd3};
        if (obs !== exp_v) begin errors++; $display("FAIL tg_reach: got %h want %h", obs, exp_v); end
        do_action(4'b1000);
        checks++; exp_v = {6'd63, RW_GOAL, 1'b1, 1'b1, 8'd64, 16'd3};
        if (obs !== exp_v) begin errors++; $display("FAIL tg_goal: got %h want %h", obs, exp_v); end
        idle();
        checks++; exp_v = {6'd63, RW_GOAL, 1'b0, 1'b0, 8'd64, 16'd3};
        if (obs !== exp_v) begin errors++; $display("FAIL tg_term: got %h want %h", obs, exp_v); end
        idle();
        checks++; exp_v = {6'd0, 16'h0000, 1'b1, 1'b0, 8'd0, 16'd4};
        if (obs !== exp_v) begin errors++; $display("FAIL tg_restart: got %h want %h", obs, exp_v); end
        idle();
        checks++; exp_v = {6'd0, 16'h0000, 1'b0, 1'b0, 8'd0, 16'd4};
        if (obs !== exp_v) begin errors++; $display("FAIL tg_single_pulse: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_term();
        walk(4'b1000, 6);
        walk(4'b0010, 7);
        do_action(4'b1000);
        checks++; exp_v = {6'd63, RW_GOAL, 1'b1, 1'b1, 8'd14, 16'd4};
        if (obs !== exp_v) begin errors++; $display("FAIL rt_goal: got %h want %h", obs, exp_v); end
        rst = 1'b1; action_valid = 1'b0;
        tick();
        checks++; exp_v = {6'd0, 16'h0000, 1'b0, 1'b0, 8'd0, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL rt_reset: got %h want %h", obs, exp_v); end
        rst = 1'b0;
        idle();
        checks++; exp_v = {6'd0, 16'h0000, 1'b0, 1'b0, 8'd0, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL rt_no_restart: got %h want %h", obs, exp_v); end
        do_action(4'b1000);
        checks++; exp_v = {6'd1, RW_STEP, 1'b1, 1'b0, 8'd1, 16'd0};
        if (obs !== exp_v) begin errors++; $display("FAIL rt_run: got %h want %h", obs, exp_v); end
        idle();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; action_valid = 1'b0; action = 4'b0000;
        test_reset();
        test_step();
        test_wall();
        test_freeze();
        test_goal();
        test_pit();
        test_timeout();
        test_timeout_goal();
        test_reset_term();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
